// File: rtl/lane_swapper_stream_if.sv
// Valid/ready stream bundle for lane_swapper_stream: input side, output side and the status counter.
// The DUT connects through the slave modport and the upstream/downstream driver through master.
interface lane_swapper_stream_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  perm_count;

    modport slave (
        input  in_valid, data_in, mode, out_ready,
        output in_ready, out_valid, data_out, perm_count
    );

    modport master (
        output in_valid, data_in, mode, out_ready,
        input  in_ready, out_valid, data_out, perm_count
    );
endinterface

// File: rtl/lane_swapper_stream.sv
// Streaming lane permuter (pass / pair swap / reverse / rotate-left) feeding a 2-entry output FIFO,
// with a saturating count of permuted beats.
module lane_swapper_stream #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lane_swapper_stream_if.slave   bus
);
    localparam int N = (LANE_W > 0) ? (DATA_W / LANE_W) : 2;

    generate
        if (LANE_W < 1) begin : g_bad_lane
            $fatal(1, "lane_swapper_stream: LANE_W must be at least 1");
        end else if ((DATA_W % (2 * LANE_W)) != 0) begin : g_bad_width
            $fatal(1, "lane_swapper_stream: DATA_W must be a multiple of 2*LANE_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t              r_occ;
    occ_t              w_occNext;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_perm;
    logic              w_inReady;
    logic              w_outValid;
    logic              w_accept;
    logic              w_pop;
    logic              w_loadHead;
    logic              w_headFromTail;
    logic              w_loadTail;

    // Handshake flags come only from the occupancy register, so in_ready never depends on out_ready.
    assign w_inReady      = (r_occ != OCC_FULL);
    assign w_outValid     = (r_occ != OCC_EMPTY);
    assign w_accept       = bus.in_valid & w_inReady;
    assign w_pop          = w_outValid & bus.out_ready;

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = w_outValid;
    assign bus.data_out   = r_head;
    assign bus.perm_count = r_count;

    always_comb begin
        w_perm = '0;
        for (int i = 0; i < N; i++) begin
            unique case (bus.mode)
                2'b00:   w_perm[i*LANE_W +: LANE_W] = bus.data_in[i*LANE_W +: LANE_W];
                2'b01:   w_perm[i*LANE_W +: LANE_W] = bus.data_in[(i ^ 1)*LANE_W +: LANE_W];
                2'b10:   w_perm[i*LANE_W +: LANE_W] = bus.data_in[(N-1-i)*LANE_W +: LANE_W];
                default: w_perm[i*LANE_W +: LANE_W] = bus.data_in[((i+N-1) % N)*LANE_W +: LANE_W];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occNext;
        end
    end

    // With one entry, a simultaneous pop and accept overwrites the head in place.
    always_comb begin
        w_occNext      = r_occ;
        w_loadHead     = 1'b0;
        w_headFromTail = 1'b0;
        w_loadTail     = 1'b0;
        unique case (r_occ)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_loadHead = 1'b1;
                    w_occNext  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (w_accept && w_pop) begin
                    w_loadHead = 1'b1;
                end else if (w_accept) begin
                    w_loadTail = 1'b1;
                    w_occNext  = OCC_FULL;
                end else if (w_pop) begin
                    w_occNext  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_pop) begin
                    w_headFromTail = 1'b1;
                    w_occNext      = OCC_ONE;
                end
            end
            default: begin
                w_occNext = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_loadHead) begin
                r_head <= w_perm;
            end else if (w_headFromTail) begin
                r_head <= r_tail;
            end
            if (w_loadTail) begin
                r_tail <= w_perm;
            end
            if (w_accept && (bus.mode != 2'b00) && (r_count != '1)) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_lane_swapper_stream.sv
// Directed and randomized checks of lane_swapper_stream in three parameterizations:
// nibble lanes, byte lanes, and a 4-bit permuted-beat counter.
module tb_lane_swapper_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecCount  = 0;
    int   missCount = 0;

    always #5 clk = ~clk;

    lane_swapper_stream_if #(.DATA_W(32), .CNT_W(16)) busA ();
    lane_swapper_stream_if #(.DATA_W(32), .CNT_W(16)) busB ();
    lane_swapper_stream_if #(.DATA_W(32), .CNT_W(4))  busC ();

    lane_swapper_stream #(.DATA_W(32), .LANE_W(4), .CNT_W(16)) dutNibble (.clk(clk), .rst(rst), .bus(busA));
    lane_swapper_stream #(.DATA_W(32), .LANE_W(8), .CNT_W(16)) dutByte   (.clk(clk), .rst(rst), .bus(busB));
    lane_swapper_stream #(.DATA_W(32), .LANE_W(4), .CNT_W(4))  dutSat    (.clk(clk), .rst(rst), .bus(busC));

    // Nibble-lane reference built from masks and shifts rather than a lane loop.
    function automatic logic [31:0] refPerm(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        r = 32'h0;
        case (m)
            2'b00: r = d;
            2'b01: r = ((d & 32'h0F0F0F0F) << 4) | ((d >> 4) & 32'h0F0F0F0F);
            2'b10: for (int k = 0; k < 8; k++) r = (r << 4) | ((d >> (4 * k)) & 32'hF);
            default: r = {d[27:0], d[31:28]};
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        busA.in_valid = 1'b0; busA.data_in = '0; busA.mode = 2'b00; busA.out_ready = 1'b0;
        busB.in_valid = 1'b0; busB.data_in = '0; busB.mode = 2'b00; busB.out_ready = 1'b0;
        busC.in_valid = 1'b0; busC.data_in = '0; busC.mode = 2'b00; busC.out_ready = 1'b0;
    endtask

    task automatic pulseReset();
        idleAll();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idleAll();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vecCount++;
        if (busA.out_valid !== 1'b0) begin
            $display("[TB] FAIL reset_out_valid: got %b want 0", busA.out_valid); missCount++;
        end
        vecCount++;
        if (busA.in_ready !== 1'b1) begin
            $display("[TB] FAIL reset_in_ready: got %b want 1", busA.in_ready); missCount++;
        end
        vecCount++;
        if (busA.data_out !== 32'h0) begin
            $display("[TB] FAIL reset_data_out: got %h want 00000000", busA.data_out); missCount++;
        end
        vecCount++;
        if (busA.perm_count !== 16'd0) begin
            $display("[TB] FAIL reset_perm_count: got %0d want 0", busA.perm_count); missCount++;
        end
        vecCount++;
        if (busC.out_valid !== 1'b0 || busC.perm_count !== 4'd0) begin
            $display("[TB] FAIL reset_sat: got valid=%b count=%0d want valid=0 count=0",
                     busC.out_valid, busC.perm_count); missCount++;
        end
    endtask

    task automatic test_nibble_modes();
        logic [31:0] expWords [4];
        expWords[0] = 32'h12345678;
        expWords[1] = 32'h21436587;
        expWords[2] = 32'h87654321;
        expWords[3] = 32'h23456781;
        pulseReset();
        busA.out_ready = 1'b1;
        busA.in_valid  = 1'b1;
        busA.data_in   = 32'h12345678;
        for (int m = 0; m < 4; m++) begin
            busA.mode = 2'(m);
            tick();
            vecCount++;
            if (busA.out_valid !== 1'b1 || busA.data_out !== expWords[m]) begin
                $display("[TB] FAIL nibble_mode%0d: got valid=%b data=%h want valid=1 data=%h",
                         m, busA.out_valid, busA.data_out, expWords[m]); missCount++;
            end
        end
        busA.in_valid = 1'b0;
        busA.mode     = 2'b00;
        tick();
        vecCount++;
        if (busA.out_valid !== 1'b0) begin
            $display("[TB] FAIL nibble_drain: got valid=%b want 0", busA.out_valid); missCount++;
        end
        vecCount++;
        if (busA.perm_count !== 16'd3) begin
            $display("[TB] FAIL nibble_perm_count: got %0d want 3", busA.perm_count); missCount++;
        end
    endtask

    task automatic test_byte_lanes();
        pulseReset();
        busB.out_ready = 1'b1;
        busB.in_valid  = 1'b1;
        busB.data_in   = 32'hAABBCCDD;
        busB.mode      = 2'b01;
        tick();
        vecCount++;
        if (busB.data_out !== 32'hBBAADDCC) begin
            $display("[TB] FAIL byte_pair_swap: got %h want BBAADDCC", busB.data_out); missCount++;
        end
        busB.mode = 2'b10;
        tick();
        vecCount++;
        if (busB.data_out !== 32'hDDCCBBAA) begin
            $display("[TB] FAIL byte_reverse: got %h want DDCCBBAA", busB.data_out); missCount++;
        end
        busB.mode = 2'b11;
        tick();
        vecCount++;
        if (busB.data_out !== 32'hBBCCDDAA) begin
            $display("[TB] FAIL byte_rotate: got %h want BBCCDDAA", busB.data_out); missCount++;
        end
        busB.in_valid = 1'b0;
        tick();
        vecCount++;
        if (busB.perm_count !== 16'd3) begin
            $display("[TB] FAIL byte_perm_count: got %0d want 3", busB.perm_count); missCount++;
        end
    endtask

    task automatic test_backpressure();
        pulseReset();
        busA.out_ready = 1'b0;
        busA.in_valid  = 1'b1;
        busA.mode      = 2'b00;
        busA.data_in   = 32'h11111111;
        tick();
        vecCount++;
        if (busA.in_ready !== 1'b1) begin
            $display("[TB] FAIL bp_ready_one: got %b want 1", busA.in_ready); missCount++;
        end
        busA.data_in = 32'h22222222;
        tick();
        vecCount++;
        if (busA.in_ready !== 1'b0 || busA.data_out !== 32'h11111111) begin
            $display("[TB] FAIL bp_full: got ready=%b data=%h want ready=0 data=11111111",
                     busA.in_ready, busA.data_out); missCount++;
        end
        busA.data_in = 32'h33333333;
        tick();
        vecCount++;
        if (busA.out_valid !== 1'b1 || busA.data_out !== 32'h11111111) begin
            $display("[TB] FAIL bp_stall_hold: got valid=%b data=%h want valid=1 data=11111111",
                     busA.out_valid, busA.data_out); missCount++;
        end
        busA.in_valid  = 1'b0;
        busA.out_ready = 1'b1;
        tick();
        vecCount++;
        if (busA.in_ready !== 1'b1 || busA.data_out !== 32'h22222222) begin
            $display("[TB] FAIL bp_first_pop: got ready=%b data=%h want ready=1 data=22222222",
                     busA.in_ready, busA.data_out); missCount++;
        end
        tick();
        vecCount++;
        if (busA.out_valid !== 1'b0) begin
            $display("[TB] FAIL bp_no_third: got valid=%b data=%h want valid=0",
                     busA.out_valid, busA.data_out); missCount++;
        end
    endtask

    task automatic test_streaming();
        logic [31:0] q[$];
        int          accepted;
        int          cyc;
        int          expPerm;
        logic        doPop;
        logic        doPush;
        accepted = 0;
        cyc      = 0;
        expPerm  = 0;
        pulseReset();
        while (accepted < 100 && cyc < 3000) begin
            vecCount++;
            if (busA.out_valid !== (q.size() != 0) || busA.in_ready !== (q.size() != 2)) begin
                $display("[TB] FAIL stream_flags cyc%0d: got valid=%b ready=%b want occ=%0d",
                         cyc, busA.out_valid, busA.in_ready, q.size()); missCount++;
            end
            if (q.size() != 0) begin
                vecCount++;
                if (busA.data_out !== q[0]) begin
                    $display("[TB] FAIL stream_data cyc%0d: got %h want %h", cyc, busA.data_out, q[0]);
                    missCount++;
                end
            end
            busA.out_ready = ($urandom_range(0, 3) != 0);
            busA.in_valid  = ($urandom_range(0, 3) != 0);
            busA.data_in   = $urandom;
            busA.mode      = 2'($urandom_range(0, 3));
            doPop  = (q.size() != 0) && busA.out_ready;
            doPush = busA.in_valid && (q.size() != 2);
            if (doPop) void'(q.pop_front());
            if (doPush) begin
                q.push_back(refPerm(busA.data_in, busA.mode));
                accepted++;
                if (busA.mode != 2'b00) expPerm++;
            end
            tick();
            cyc++;
        end
        if (accepted < 100) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL stream_timeout: got %0d beats want 100", accepted);
        end
        busA.in_valid  = 1'b0;
        busA.out_ready = 1'b1;
        for (int d = 0; d < 4 && q.size() != 0; d++) begin
            vecCount++;
            if (busA.out_valid !== 1'b1 || busA.data_out !== q[0]) begin
                $display("[TB] FAIL stream_drain: got valid=%b data=%h want valid=1 data=%h",
                         busA.out_valid, busA.data_out, q[0]); missCount++;
            end
            void'(q.pop_front());
            tick();
        end
        vecCount++;
        if (busA.out_valid !== 1'b0) begin
            $display("[TB] FAIL stream_empty: got valid=%b want 0", busA.out_valid); missCount++;
        end
        vecCount++;
        if (busA.perm_count !== 16'(expPerm)) begin
            $display("[TB] FAIL stream_perm_count: got %0d want %0d", busA.perm_count, expPerm); missCount++;
        end
    endtask

    task automatic test_saturation();
        pulseReset();
        busC.out_ready = 1'b1;
        busC.in_valid  = 1'b1;
        busC.mode      = 2'b10;
        for (int b = 0; b < 10; b++) begin
            busC.data_in = 32'h01020304 + 32'(b);
            tick();
        end
        vecCount++;
        if (busC.perm_count !== 4'd10) begin
            $display("[TB] FAIL sat_mid: got %0d want 10", busC.perm_count); missCount++;
        end
        for (int b = 0; b < 10; b++) begin
            busC.data_in = 32'hA0B0C0D0 + 32'(b);
            tick();
        end
        busC.in_valid = 1'b0;
        tick();
        vecCount++;
        if (busC.perm_count !== 4'd15) begin
            $display("[TB] FAIL sat_final: got %0d want 15", busC.perm_count); missCount++;
        end
    endtask

    task automatic test_reset_midstream();
        pulseReset();
        busA.out_ready = 1'b0;
        busA.in_valid  = 1'b1;
        busA.mode      = 2'b01;
        busA.data_in   = 32'hA5A5A5A5;
        tick();
        busA.data_in = 32'h5A5A5A5A;
        tick();
        vecCount++;
        if (busA.in_ready !== 1'b0 || busA.perm_count !== 16'd2) begin
            $display("[TB] FAIL mid_full: got ready=%b count=%0d want ready=0 count=2",
                     busA.in_ready, busA.perm_count); missCount++;
        end
        busA.data_in = 32'hDEADBEEF;
        busA.mode    = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busA.in_valid = 1'b0;
        vecCount++;
        if (busA.out_valid !== 1'b0 || busA.perm_count !== 16'd0 || busA.in_ready !== 1'b1) begin
            $display("[TB] FAIL mid_reset: got valid=%b count=%0d ready=%b want valid=0 count=0 ready=1",
                     busA.out_valid, busA.perm_count, busA.in_ready); missCount++;
        end
        busA.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vecCount++;
            if (busA.out_valid !== 1'b0) begin
                $display("[TB] FAIL mid_stale%0d: got valid=%b data=%h want valid=0",
                         c, busA.out_valid, busA.data_out); missCount++;
            end
        end
    endtask

    initial begin
        idleAll();
        test_reset();
        test_nibble_modes();
        test_byte_lanes();
        test_backpressure();
        test_streaming();
        test_saturation();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/lane_swapper_stream.md
Name: lane_swapper_stream

Overview:
- Parametrised, streaming generalisation of the nibble swap function.
- Splits a DATA_W-bit word into LANE_W-bit lanes and applies one of four per-beat lane permutations: pass, adjacent-pair swap, full reversal, rotate-left-by-one.
- Sits on a valid/ready datapath with a 2-entry output buffer, giving full throughput and a registered in_ready.
- Also keeps a saturating count of beats that were actually permuted, for debug and status readback.

Parameters:
- DATA_W, 32, datapath width in bits; must be a multiple of 2*LANE_W.
- LANE_W, 4, lane width in bits; 4 gives the classic nibble swap, 8 gives a byte swap.
- CNT_W, 16, width of the permuted-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- data_in  in  DATA_W  input word.
- mode  in  2  permutation for this beat, qualified by in_valid: 00 pass, 01 pair swap, 10 reverse, 11 rotate-left.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat.
- data_out  out  DATA_W  permuted word.
- perm_count  out  CNT_W  saturating count of accepted beats with mode != 00.

Interface decision: one clock; reset is synchronous and active-high, ports named clk and rst.

Behaviour:
- Lane numbering: lane i = data[i*LANE_W +: LANE_W]; N = DATA_W/LANE_W, which is always even.
- Permutations, where out lane i takes:
  - Pass: in lane i.
  - Pair swap: in lane i^1.
  - Reverse: in lane N-1-i.
  - Rotate-left: in lane (i-1) mod N, i.e. {data_in[DATA_W-LANE_W-1:0], data_in[DATA_W-1:DATA_W-LANE_W]}.
- Permutation is applied combinationally on the input side. The permuted word is written into the buffer. mode is captured only on acceptance; mode changes while not accepting have no effect.
- Accept: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Buffer: 2-entry FIFO with occupancy occ in 0..2.
  - in_ready = (occ != 2). It is a function of registered state only, with no combinational path from out_ready.
  - out_valid = (occ != 0). data_out = head entry, driven from a register.
- Latency: a beat accepted in cycle N into an empty buffer appears on data_out with out_valid=1 in cycle N+1.
- Throughput: one beat per cycle while out_ready stays high.
- Occupancy update:
  - Simultaneous accept and transfer leaves occ unchanged; the new beat is written behind the head, or into head when occ=1 (head leaves while tail arrives).
  - occ=2 with out_ready=1: pop only. in_ready rises the next cycle.
  - occ=0 with out_ready=1 and no accept: nothing happens; out_valid stays 0.
- Ordering is strictly FIFO. Each beat keeps the mode it was accepted with, even if mode changes between beats.
- Output stability: while out_valid=1 and out_ready=0, data_out and out_valid hold stable.
- perm_count: increments by 1 on each accept with mode != 00. It saturates at 2^CNT_W-1 and never wraps.
- Reset (rst=1 at a clock edge): occ=0, out_valid=0, in_ready=1 (from the cycle after rst deasserts), data_out=0, perm_count=0.
  - Reset mid-stream discards buffered beats; none are emitted after reset.
  - Inputs are ignored while rst=1.
- Elaboration: fatal error if DATA_W % (2*LANE_W) != 0 or LANE_W < 1.

Test Plan:
- DATA_W=32, LANE_W=4, out_ready=1; send 0x12345678 with modes 00, 01, 10, 11 on consecutive cycles -> data_out 0x12345678, 0x21436587, 0x87654321, 0x23456781 on the next four cycles; perm_count=3.
- LANE_W=8, mode=01, data_in 0xAABBCCDD -> 0xBBAADDCC. Mode=10 -> 0xDDCCBBAA.
- Backpressure: out_ready=0; push 0x11111111 then 0x22222222 -> in_ready=0 after the second accept and a third beat is not accepted. Raise out_ready -> 0x11111111 then 0x22222222 emitted in order; in_ready returns to 1 one cycle after the first pop.
- Streaming: 100 random beats with random out_ready -> output sequence matches the reference model and order; data_out is stable whenever stalled.
- Saturation: CNT_W=4; 20 beats with mode=10 -> perm_count stops at 15.
- Reset mid-stream: occ=2, assert rst one cycle -> out_valid=0, perm_count=0 next cycle; no stale beat appears afterwards.
